muldiv_unit: RTL and testbench

Iterative multi-cycle execution unit for the RV32M instructions that the decoder flags with alu_control codes 4'b1000–4'b1111. It sits beside the single-cycle ALU in the execute stage and accepts one operation per start/done handshake. It returns a WIDTH-bit result after a fixed latency; the pipeline stalls on busy.

---
 rtl/muldiv_unit.sv | 134 +++++++++++++
 tb/tb_muldiv_unit.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, one bit per cycle.
// Optional MULDIV_EARLY_OUT_EN: divide-by-zero and signed overflow skip the iteration.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             kill,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state_q;
  logic [CW-1:0]      count_q;
  logic [2:0]         op_q;
  logic               aNeg_q, bNeg_q, done_q;
  logic [WIDTH-1:0]   aMag_q, bMag_q, result_q;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   result_d;

  logic               aSigned, bSigned, aNeg, bNeg, divZero;
  logic [WIDTH-1:0]   aMag, bMag, quot, rem, aOrig;
  logic [WIDTH:0]     mulSum, remSh, diff;
  logic [2*WIDTH-1:0] prodSigned;

`ifdef MULDIV_EARLY_OUT_EN
  logic             inZero, inOvf, early;
  logic [WIDTH-1:0] earlyResult;
`endif

  always_comb begin
    aSigned = op[2] ? ~op[0] : (op[1:0] != 2'b11);
    bSigned = op[2] ? ~op[0] : ~op[1];
    aNeg    = aSigned & a[WIDTH-1];
    bNeg    = bSigned & b[WIDTH-1];
    aMag    = aNeg ? -a : a;
    bMag    = bNeg ? -b : b;

    // Multiply keeps {partial, multiplier} and shifts right; divide keeps {remainder, dividend/quotient} and shifts left.
    mulSum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, aMag_q} : '0);
    remSh  = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
    diff   = remSh - {1'b0, bMag_q};
    if (op_q[2]) begin
      if (diff[WIDTH]) prod_d = {remSh[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0};
      else             prod_d = {diff[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
    end else begin
      prod_d = {mulSum, prod_q[WIDTH-1:1]};
    end

    prodSigned = (aNeg_q ^ bNeg_q) ? -prod_d : prod_d;
    quot       = (aNeg_q ^ bNeg_q) ? -prod_d[WIDTH-1:0] : prod_d[WIDTH-1:0];
    rem        = aNeg_q ? -prod_d[2*WIDTH-1:WIDTH] : prod_d[2*WIDTH-1:WIDTH];
    aOrig      = aNeg_q ? -aMag_q : aMag_q;
    divZero    = (bMag_q == '0);
    case (op_q)
      3'b000:                 result_d = prodSigned[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: result_d = prodSigned[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:         result_d = divZero ? '1 : quot;
      default:                result_d = divZero ? aOrig : rem;
    endcase

`ifdef MULDIV_EARLY_OUT_EN
    inZero = (b == '0);
    inOvf  = ~op[0] & (a == {1'b1, {(WIDTH-1){1'b0}}}) & (b == '1);
    early  = op[2] & (inZero | inOvf);
    if (inZero) earlyResult = op[1] ? a : '1;
    else        earlyResult = op[1] ? '0 : a;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      count_q  <= '0;
      op_q     <= '0;
      aNeg_q   <= 1'b0;
      bNeg_q   <= 1'b0;
      aMag_q   <= '0;
      bMag_q   <= '0;
      prod_q   <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else if (kill) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start && op[3]) begin
          op_q    <= op[2:0];
          aNeg_q  <= aNeg;
          bNeg_q  <= bNeg;
          aMag_q  <= aMag;
          bMag_q  <= bMag;
          count_q <= '0;
          prod_q  <= {{WIDTH{1'b0}}, (op[2] ? aMag : bMag)};
          state_q <= CALC;
`ifdef MULDIV_EARLY_OUT_EN
          if (early) begin
            state_q  <= DONE;
            done_q   <= 1'b1;
            result_q <= earlyResult;
          end
`endif
        end
        CALC: begin
          prod_q  <= prod_d;
          count_q <= count_q + 1'b1;
          if (count_q == CW'(WIDTH-1)) begin
            state_q  <= DONE;
            done_q   <= 1'b1;
            result_q <= result_d;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (WIDTH=32); latency expectations follow MULDIV_EARLY_OUT_EN.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n, start, kill;
  logic [3:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

`ifdef MULDIV_EARLY_OUT_EN
  localparam int SPECIAL_LAT = 1;
`else
  localparam int SPECIAL_LAT = 33;
`endif

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .kill(kill), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  // Starts an operation in the cycle after the call, then returns in the done cycle.
  task automatic run_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] r, output int lat, output int busyBad);
    @(posedge clk); #1;
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1; busyBad = 0; r = 'x;
    for (int c = 1; c <= 200; c++) begin
      if (!busy) busyBad++;
      if (done) begin
        lat = c; r = result;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; kill = 1'b0; op = 4'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    checks++; if (result !== 32'h0) begin errors++; $display("[TB] FAIL reset_result: got %h expected 00000000", result); end
    rst_n = 1'b1;
  endtask

  task automatic test_mul();
    logic [31:0] r; int lat, bb;
    run_op(4'b1000, 32'd7, 32'hFFFFFFFD, r, lat, bb);
    checks++; if (r !== 32'hFFFFFFEB) begin errors++; $display("[TB] FAIL mul_result: got %h expected ffffffeb", r); end
    checks++; if (lat !== 33) begin errors++; $display("[TB] FAIL mul_latency: got %0d expected 33", lat); end
    checks++; if (bb !== 0) begin errors++; $display("[TB] FAIL mul_busy_window: got %0d low cycles expected 0", bb); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL mul_busy_after: got %b expected 0", busy); end
  endtask

  task automatic test_mul_high();
    logic [31:0] r; int lat, bb;
    run_op(4'b1001, 32'h80000000, 32'h80000000, r, lat, bb);
    checks++; if (r !== 32'h40000000) begin errors++; $display("[TB] FAIL mulh: got %h expected 40000000", r); end
    run_op(4'b1011, 32'hFFFFFFFF, 32'hFFFFFFFF, r, lat, bb);
    checks++; if (r !== 32'hFFFFFFFE) begin errors++; $display("[TB] FAIL mulhu: got %h expected fffffffe", r); end
    run_op(4'b1010, 32'hFFFFFFFF, 32'hFFFFFFFF, r, lat, bb);
    checks++; if (r !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL mulhsu: got %h expected ffffffff", r); end
  endtask

  task automatic test_div();
    logic [31:0] r; int lat, bb;
    run_op(4'b1100, 32'hFFFFFFF9, 32'd2, r, lat, bb);
    checks++; if (r !== 32'hFFFFFFFD) begin errors++; $display("[TB] FAIL div_neg: got %h expected fffffffd", r); end
    checks++; if (lat !== 33) begin errors++; $display("[TB] FAIL div_latency: got %0d expected 33", lat); end
    run_op(4'b1110, 32'hFFFFFFF9, 32'd2, r, lat, bb);
    checks++; if (r !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL rem_neg: got %h expected ffffffff", r); end
    run_op(4'b1101, 32'd7, 32'd2, r, lat, bb);
    checks++; if (r !== 32'd3) begin errors++; $display("[TB] FAIL divu: got %h expected 00000003", r); end
    run_op(4'b1111, 32'd7, 32'd2, r, lat, bb);
    checks++; if (r !== 32'd1) begin errors++; $display("[TB] FAIL remu: got %h expected 00000001", r); end
  endtask

  task automatic test_special();
    logic [31:0] r; int lat, bb;
    run_op(4'b1100, 32'd5, 32'd0, r, lat, bb);
    checks++; if (r !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL div_by_zero: got %h expected ffffffff", r); end
    checks++; if (lat !== SPECIAL_LAT) begin errors++; $display("[TB] FAIL div_by_zero_latency: got %0d expected %0d", lat, SPECIAL_LAT); end
    run_op(4'b1111, 32'd5, 32'd0, r, lat, bb);
    checks++; if (r !== 32'd5) begin errors++; $display("[TB] FAIL remu_by_zero: got %h expected 00000005", r); end
    run_op(4'b1100, 32'hFFFFFFFB, 32'd0, r, lat, bb);
    checks++; if (r !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL div_neg_by_zero: got %h expected ffffffff", r); end
    run_op(4'b1110, 32'hFFFFFFFB, 32'd0, r, lat, bb);
    checks++; if (r !== 32'hFFFFFFFB) begin errors++; $display("[TB] FAIL rem_neg_by_zero: got %h expected fffffffb", r); end
    run_op(4'b1100, 32'h80000000, 32'hFFFFFFFF, r, lat, bb);
    checks++; if (r !== 32'h80000000) begin errors++; $display("[TB] FAIL div_overflow: got %h expected 80000000", r); end
    checks++; if (lat !== SPECIAL_LAT) begin errors++; $display("[TB] FAIL div_overflow_latency: got %0d expected %0d", lat, SPECIAL_LAT); end
    run_op(4'b1110, 32'h80000000, 32'hFFFFFFFF, r, lat, bb);
    checks++; if (r !== 32'h0) begin errors++; $display("[TB] FAIL rem_overflow: got %h expected 00000000", r); end
  endtask

  task automatic test_ignored_op();
    int busySeen = 0;
    @(posedge clk); #1;
    start = 1'b1; op = 4'b0000; a = 32'd3; b = 32'd4;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (busy) busySeen++;
      @(posedge clk); #1;
    end
    checks++; if (busySeen !== 0) begin errors++; $display("[TB] FAIL non_m_op_ignored: got %0d busy cycles expected 0", busySeen); end
  endtask

  task automatic test_start_while_busy();
    int lat = -1;
    logic [31:0] r = 'x;
    @(posedge clk); #1;
    start = 1'b1; op = 4'b1000; a = 32'd3; b = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1; op = 4'b1000; a = 32'd100; b = 32'd100;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 6; c <= 200; c++) begin
      if (done) begin lat = c; r = result; break; end
      @(posedge clk); #1;
    end
    checks++; if (r !== 32'd15) begin errors++; $display("[TB] FAIL busy_start_result: got %h expected 0000000f", r); end
    checks++; if (lat !== 33) begin errors++; $display("[TB] FAIL busy_start_latency: got %0d expected 33", lat); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r; int lat, bb;
    run_op(4'b1101, 32'd100, 32'd7, r, lat, bb);
    checks++; if (r !== 32'd14) begin errors++; $display("[TB] FAIL b2b_first: got %h expected 0000000e", r); end
    run_op(4'b1111, 32'd100, 32'd7, r, lat, bb);
    checks++; if (r !== 32'd2) begin errors++; $display("[TB] FAIL b2b_second: got %h expected 00000002", r); end
    checks++; if (lat !== 33) begin errors++; $display("[TB] FAIL b2b_latency: got %0d expected 33", lat); end
  endtask

  task automatic test_kill();
    logic [31:0] r; int lat, bb;
    int doneSeen = 0;
    run_op(4'b1000, 32'd9, 32'd9, r, lat, bb);
    checks++; if (r !== 32'd81) begin errors++; $display("[TB] FAIL kill_setup: got %h expected 00000051", r); end
    @(posedge clk); #1;
    start = 1'b1; op = 4'b1000; a = 32'd6; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL kill_busy: got %b expected 0", busy); end
    for (int c = 0; c < 40; c++) begin
      if (done) doneSeen++;
      @(posedge clk); #1;
    end
    checks++; if (doneSeen !== 0) begin errors++; $display("[TB] FAIL kill_no_done: got %0d done cycles expected 0", doneSeen); end
    checks++; if (result !== 32'd81) begin errors++; $display("[TB] FAIL kill_result_held: got %h expected 00000051", result); end
  endtask

  task automatic test_reset_mid();
    int doneSeen = 0;
    @(posedge clk); #1;
    start = 1'b1; op = 4'b1000; a = 32'd11; b = 32'd13;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midreset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL midreset_done: got %b expected 0", done); end
    checks++; if (result !== 32'h0) begin errors++; $display("[TB] FAIL midreset_result: got %h expected 00000000", result); end
    for (int c = 0; c < 40; c++) begin
      if (done) doneSeen++;
      @(posedge clk); #1;
    end
    checks++; if (doneSeen !== 0) begin errors++; $display("[TB] FAIL midreset_no_done: got %0d done cycles expected 0", doneSeen); end
  endtask

  task automatic test_kill_start();
    int busySeen = 0;
    @(posedge clk); #1;
    start = 1'b1; kill = 1'b1; op = 4'b1000; a = 32'd2; b = 32'd2;
    @(posedge clk); #1;
    start = 1'b0; kill = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (busy || done) busySeen++;
      @(posedge clk); #1;
    end
    checks++; if (busySeen !== 0) begin errors++; $display("[TB] FAIL kill_start_no_accept: got %0d active cycles expected 0", busySeen); end
  endtask

  initial begin
    $display("[TB] muldiv_unit directed test");
    test_reset();
    test_mul();
    test_mul_high();
    test_div();
    test_special();
    test_ignored_op();
    test_start_while_busy();
    test_back_to_back();
    test_kill();
    test_reset_mid();
    test_kill_start();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
